// File: rtl/ss_pkg.sv
// Shared types and constants for the map sequencer: FSM states, index width helper, default trigger column.
package ss_pkg;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_DONE   = 2'd2
    } ss_state_e;

    localparam logic [7:0] TRIGGER_X_DEF = 8'h7C;

    // Index width for a map count; never narrower than one bit.
    function automatic int map_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ss_edge_det.sv
// Arrival detector: registers the previous compare result and pulses on the first cycle val equals MATCH.
// Latency: combinational pulse in the cycle of arrival; a held value pulses once only.
module ss_edge_det #(
    parameter int           W     = 8,
    parameter logic [W-1:0] MATCH = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] val,
    output logic         pulse
);

    logic hit;
    logic hit_q;

    assign hit = (val == MATCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit;
        end
    end

    assign pulse = hit & ~hit_q;

endmodule

// File: rtl/ss_map_sequencer.sv
// Selects the active world map, advances it on player arrival at the trigger column, blanks video during transitions.
// Output data follows current_map through an RD_LAT-deep select pipeline matching the BRAM read latency.
module ss_map_sequencer
    import ss_pkg::*;
#(
    parameter int                NUM_MAPS      = 4,
    parameter int                PIX_W         = 2,
    parameter int                LOCX_W        = 8,
    parameter logic [LOCX_W-1:0] TRIGGER_X     = LOCX_W'(TRIGGER_X_DEF),
    parameter int                RD_LAT        = 1,
    parameter int                SWITCH_CYCLES = 16,
    parameter int                WRAP          = 1
) (
    input  logic                              clk_75,
    input  logic                              reset_n,
    input  logic [LOCX_W-1:0]                 LocX,
    input  logic                              restart,
    input  logic                              ovr_en,
    input  logic [map_idx_w(NUM_MAPS)-1:0]    ovr_map,
    input  logic [NUM_MAPS*PIX_W-1:0]         worldmap_bus,
    input  logic [NUM_MAPS*PIX_W-1:0]         pixel_bus,
    output logic [PIX_W-1:0]                  worldmap_data,
    output logic [PIX_W-1:0]                  world_pixel,
    output logic [map_idx_w(NUM_MAPS)-1:0]    current_map,
    output logic                              map_changed,
    output logic                              switching,
    output logic                              game_done
);

    localparam int               MAP_W    = map_idx_w(NUM_MAPS);
    localparam int               CNT_W    = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;
    localparam logic [MAP_W-1:0] LAST_MAP = MAP_W'(NUM_MAPS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SWITCH_CYCLES - 1);

    ss_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic              arrival;
    logic [MAP_W-1:0]  ovr_tgt;
    logic [MAP_W-1:0]  sel_pipe [RD_LAT];
    logic [MAP_W-1:0]  sel_d;
    logic [PIX_W-1:0]  pix_sel;

    ss_edge_det #(
        .W     (LOCX_W),
        .MATCH (TRIGGER_X)
    ) u_edge (
        .clk   (clk_75),
        .rst_n (reset_n),
        .val   (LocX),
        .pulse (arrival)
    );

    assign ovr_tgt = ({1'b0, ovr_map} > {1'b0, LAST_MAP}) ? LAST_MAP : ovr_map;

    // Priority: override, then restart, then arrival (PLAY only). The SWITCH countdown runs regardless.
    always_ff @(posedge clk_75 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_PLAY;
            cnt         <= '0;
            current_map <= '0;
            map_changed <= 1'b0;
        end else begin
            map_changed <= 1'b0;
            if (state == ST_SWITCH) begin
                if (cnt == '0) begin
                    state <= ST_PLAY;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
            if (ovr_en) begin
                if (ovr_tgt != current_map) begin
                    current_map <= ovr_tgt;
                    map_changed <= 1'b1;
                end
            end else if (restart) begin
                current_map <= '0;
                map_changed <= 1'b1;
                state       <= ST_SWITCH;
                cnt         <= CNT_LOAD;
            end else if (arrival && (state == ST_PLAY)) begin
                if (current_map != LAST_MAP) begin
                    current_map <= current_map + 1'b1;
                    map_changed <= 1'b1;
                    state       <= ST_SWITCH;
                    cnt         <= CNT_LOAD;
                end else if (WRAP != 0) begin
                    current_map <= '0;
                    map_changed <= 1'b1;
                    state       <= ST_SWITCH;
                    cnt         <= CNT_LOAD;
                end else begin
                    state <= ST_DONE;
                end
            end
        end
    end

    assign switching = (state == ST_SWITCH);
    assign game_done = (state == ST_DONE);

    always_ff @(posedge clk_75 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) sel_pipe[i] <= '0;
        end else begin
            sel_pipe[0] <= current_map;
            for (int i = 1; i < RD_LAT; i++) sel_pipe[i] <= sel_pipe[i-1];
        end
    end

    assign sel_d = sel_pipe[RD_LAT-1];

    always_comb begin
        worldmap_data = '0;
        pix_sel       = '0;
        for (int i = 0; i < NUM_MAPS; i++) begin
            if (sel_d == MAP_W'(i)) begin
                worldmap_data = worldmap_bus[i*PIX_W +: PIX_W];
                pix_sel       = pixel_bus[i*PIX_W +: PIX_W];
            end
        end
    end

    assign world_pixel = switching ? '0 : pix_sel;

endmodule

// File: doc/ss_map_sequencer.md
SS_MAP_SEQUENCER -- requirements
Module: ss_map_sequencer

Interface
REQ-001 SHALL have parameter NUM_MAPS, default 4, meaning number of world-map BRAMs selectable (2..16).
REQ-002 SHALL have parameter PIX_W, default 2, meaning width of each map data word.
REQ-003 SHALL have parameter LOCX_W, default 8, meaning width of player X location.
REQ-004 SHALL have parameter TRIGGER_X, default 8'h7C, meaning LocX value that ends the current map.
REQ-005 SHALL have parameter RD_LAT, default 1, meaning BRAM read latency in clocks (1..3).
REQ-006 SHALL have parameter SWITCH_CYCLES, default 16, meaning blanking duration of a map transition.
REQ-007 SHALL have parameter WRAP, default 1, meaning that after the last map play returns to map 0 (1) or stops in DONE (0).
REQ-008 SHALL have port clk_75, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port LocX, input, LOCX_W bits: player X location.
REQ-011 SHALL have port restart, input, 1 bit: one-clock pulse that returns play to map 0.
REQ-012 SHALL have port ovr_en, input, 1 bit: manual map override enable (debounced switch).
REQ-013 SHALL have port ovr_map, input, $clog2(NUM_MAPS) bits: override map index.
REQ-014 SHALL have port worldmap_bus, input, NUM_MAPS*PIX_W bits: concatenated port-A outputs; map i occupies bits [i*PIX_W +: PIX_W].
REQ-015 SHALL have port pixel_bus, input, NUM_MAPS*PIX_W bits: concatenated port-B (video) outputs, same packing.
REQ-016 SHALL have port worldmap_data, output, PIX_W bits: selected collision data.
REQ-017 SHALL have port world_pixel, output, PIX_W bits: selected video data.
REQ-018 SHALL have port current_map, output, $clog2(NUM_MAPS) bits: active map index.
REQ-019 SHALL have port map_changed, output, 1 bit: one-clock pulse when current_map updates.
REQ-020 SHALL have port switching, output, 1 bit: high while in SWITCH.
REQ-021 SHALL have port game_done, output, 1 bit: high in DONE.

Function
REQ-022 SHALL run a state machine with states PLAY, SWITCH and DONE.
REQ-023 SHALL register LocX and detect "arrival": LocX == TRIGGER_X this cycle and != TRIGGER_X the previous cycle; a held LocX SHALL trigger once only.
REQ-024 PLAY + arrival with current_map < NUM_MAPS-1 SHALL increment current_map, pulse map_changed and enter SWITCH.
REQ-025 PLAY + arrival with current_map == NUM_MAPS-1 SHALL set current_map to 0 and enter SWITCH if WRAP=1, or enter DONE with current_map unchanged if WRAP=0.
REQ-026 SWITCH SHALL last exactly SWITCH_CYCLES clocks, counted by a down-counter, then return to PLAY; arrivals during SWITCH SHALL be ignored.
REQ-027 DONE SHALL be left only by restart or reset.
REQ-028 restart in any state SHALL set current_map to 0, enter SWITCH and pulse map_changed; restart has priority over a simultaneous arrival.
REQ-029 While ovr_en=1, current_map SHALL follow ovr_map (values >= NUM_MAPS clamp to NUM_MAPS-1), arrivals SHALL be ignored, and each change in value SHALL pulse map_changed without entering SWITCH; ovr_en has priority over restart.
REQ-030 The output mux select SHALL be current_map delayed by RD_LAT clocks, so that data follows the BRAM address pipeline.
REQ-031 worldmap_data SHALL be driven from the delayed select with no additional register.
REQ-032 world_pixel SHALL be forced to 0 whenever switching is high, and otherwise taken from the delayed select.

Reset
REQ-033 Assertion of reset_n SHALL immediately force state PLAY, current_map 0, select pipeline 0, counter 0, map_changed 0, switching 0 and game_done 0.
REQ-034 A reset during SWITCH or DONE SHALL abort the operation with no residual pulse after reset release.

Structure
REQ-035 State enum typedef, MAP_IDX_W function/constant and default TRIGGER_X SHALL live in shared package ss_pkg.
REQ-036 Arrival edge detection SHALL be a sub-module ss_edge_det (registered compare, pulse output).

Verification
REQ-037 Reset, then LocX 0->8'h7C held 50 clocks -> one map_changed, current_map=1, switching high exactly 16 clocks.
REQ-038 With NUM_MAPS=4 and WRAP=1, four arrivals -> current_map sequence 1,2,3,0; with WRAP=0 the fourth arrival -> game_done=1, current_map=3.
REQ-039 Arrival during SWITCH -> ignored, current_map unchanged; restart and arrival in the same clock -> current_map=0.
REQ-040 ovr_en=1 with ovr_map=2 and then 7 (NUM_MAPS=4) -> current_map 2 then 3, two map_changed pulses, switching stays 0.
REQ-041 With RD_LAT=2, distinct constants on each bus slice -> worldmap_data changes exactly 2 clocks after current_map changes.
REQ-042 reset_n low mid-SWITCH -> all outputs 0 asynchronously, then PLAY on map 0 after release.
